// File: rtl/pmic_glitch_sequencer.sv
// Parcel-based PMIC stand-in: matches I2C words on the main or private bus, then drives
// DAC updates and timed delays from a ROM-resident program.
module pmic_glitch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  i2c_main,
    input  logic        main_ready,
    input  logic [8:0]  i2c_priv,
    input  logic        priv_ready,
    output logic [7:0]  rom_addr,
    input  logic [11:0] rom_instr,
    output logic [7:0]  delay_idx,
    input  logic [31:0] delay_ref,
    output logic        dac_we,
    output logic [8:0]  dac_data,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StFetch     = 3'd1,
        StI2cWait   = 3'd2,
        StI2cCheck  = 3'd3,
        StDac       = 3'd4,
        StPrepDelay = 3'd5,
        StDelay     = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] curr_q, curr_d;
    logic [7:0]  parcel_start_q, parcel_start_d;
    logic [7:0]  depth_q, depth_d;
    logic [31:0] delay_len_q, delay_len_d;
    logic [31:0] delay_cnt_q, delay_cnt_d;

    logic        fetch_next;
    logic        action_step;
    logic        fetch_is_match;
    state_e      fetch_state;
    logic        sel_ready;
    logic [8:0]  sel_word;
    logic        unused_curr;

    assign rom_addr    = parcel_start_q + depth_q;
    assign dac_data    = curr_q[8:0];
    assign state_o     = state_q;
    assign unused_curr = ^curr_q[11:10];

    always_comb begin
        sel_ready      = curr_q[9] ? priv_ready : main_ready;
        sel_word       = curr_q[9] ? i2c_priv : i2c_main;
        fetch_is_match = ~rom_instr[11] & ~rom_instr[10];
        // Delay outranks dac when both bits are set.
        if (rom_instr[11]) begin
            fetch_state = StPrepDelay;
        end else if (rom_instr[10]) begin
            fetch_state = StDac;
        end else begin
            fetch_state = StI2cWait;
        end
    end

    always_comb begin
        state_d        = state_q;
        curr_d         = curr_q;
        parcel_start_d = parcel_start_q;
        depth_d        = depth_q;
        delay_len_d    = delay_len_q;
        delay_cnt_d    = delay_cnt_q;
        dac_we         = 1'b0;
        delay_idx      = 8'd0;
        fetch_next     = 1'b0;
        action_step    = 1'b0;

        unique case (state_q)
            StInit: begin
                parcel_start_d = 8'd0;
                depth_d        = 8'd0;
                curr_d         = 12'd0;
                state_d        = StFetch;
            end
            StFetch: begin
                curr_d  = rom_instr;
                depth_d = 8'd1;
                state_d = fetch_state;
            end
            StI2cWait: begin
                if (sel_ready) begin
                    state_d = StI2cCheck;
                end
            end
            StI2cCheck: begin
                if (sel_word == curr_q[8:0]) begin
                    fetch_next = 1'b1;
                end else begin
                    depth_d = 8'd0;
                    state_d = StFetch;
                end
            end
            StDac: begin
                dac_we      = 1'b1;
                fetch_next  = 1'b1;
                action_step = 1'b1;
            end
            StPrepDelay: begin
                delay_idx   = curr_q[8:1];
                delay_len_d = delay_ref;
                delay_cnt_d = 32'd0;
                state_d     = StDelay;
            end
            StDelay: begin
                delay_cnt_d = delay_cnt_q + 32'd1;
                if (delay_cnt_q > delay_len_q) begin
                    fetch_next  = 1'b1;
                    action_step = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase

        if (fetch_next) begin
            curr_d  = rom_instr;
            state_d = fetch_state;
            // A match word after an action opens a new parcel.
            if (action_step && fetch_is_match) begin
                parcel_start_d = rom_addr;
                depth_d        = 8'd1;
            end else begin
                depth_d = depth_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StInit;
            curr_q         <= 12'd0;
            parcel_start_q <= 8'd0;
            depth_q        <= 8'd0;
            delay_len_q    <= 32'd0;
            delay_cnt_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            curr_q         <= curr_d;
            parcel_start_q <= parcel_start_d;
            depth_q        <= depth_d;
            delay_len_q    <= delay_len_d;
            delay_cnt_q    <= delay_cnt_d;
        end
    end

endmodule

// File: tb/tb_pmic_glitch_sequencer.sv
// Bench for pmic_glitch_sequencer: directed scenarios plus a randomized program run against a
// word-level interpreter of the parcel rules.
module tb_pmic_glitch_sequencer;

    logic        clk;
    logic        reset;
    logic [8:0]  i2c_main;
    logic        main_ready;
    logic [8:0]  i2c_priv;
    logic        priv_ready;
    logic [7:0]  rom_addr;
    logic [11:0] rom_instr;
    logic [7:0]  delay_idx;
    logic [31:0] delay_ref;
    logic        dac_we;
    logic [8:0]  dac_data;
    logic [2:0]  state_o;

    logic [11:0] rom  [256];
    logic [31:0] dtab [256];

    int nvec = 0;
    int nerr = 0;

    assign rom_instr = rom[rom_addr];
    assign delay_ref = dtab[delay_idx];

    pmic_glitch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_main   (i2c_main),
        .main_ready (main_ready),
        .i2c_priv   (i2c_priv),
        .priv_ready (priv_ready),
        .rom_addr   (rom_addr),
        .rom_instr  (rom_instr),
        .delay_idx  (delay_idx),
        .delay_ref  (delay_ref),
        .dac_we     (dac_we),
        .dac_data   (dac_data),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 12'h000;
            dtab[i] = 32'd0;
        end
    endtask

    // Leaves the bench at a falling edge with the DUT in INIT.
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        main_ready = 1'b0;
        priv_ready = 1'b0;
        i2c_main   = 9'd0;
        i2c_priv   = 9'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle ready pulse; returns at the falling edge of the I2C_CHECK cycle.
    task automatic send_main(input logic [8:0] w);
        i2c_main   = w;
        main_ready = 1'b1;
        @(negedge clk);
        main_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        rom[0] = 12'h0A5;
        do_reset();
        nvec++;
        if (rom_addr !== 8'd0 || dac_we !== 1'b0 || delay_idx !== 8'd0) begin
            nerr++;
            $display("FAIL reset_init: rom_addr=%0h dac_we=%0b delay_idx=%0h, want 0/0/0",
                     rom_addr, dac_we, delay_idx);
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd0 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL reset_fetch: rom_addr=%0h dac_we=%0b, want 0/0", rom_addr, dac_we);
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd1 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL reset_wait: rom_addr=%0h dac_we=%0b, want 1/0", rom_addr, dac_we);
        end
        repeat (3) @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd1 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle: rom_addr=%0h dac_we=%0b, want 1/0", rom_addr, dac_we);
        end
    endtask

    task automatic test_match_dac();
        clear_mem();
        rom[0] = 12'h0A5; rom[1] = 12'h5FF; rom[2] = 12'h012;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A5);
        nvec++;
        if (dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL match_check_we: dac_we=%0b, want 0", dac_we);
        end
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b1 || dac_data !== 9'h1FF) begin
            nerr++;
            $display("FAIL match_dac: dac_we=%0b dac_data=%0h, want 1/1ff", dac_we, dac_data);
        end
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b0 || rom_addr !== 8'd3) begin
            nerr++;
            $display("FAIL parcel_end: dac_we=%0b rom_addr=%0h, want 0/3", dac_we, rom_addr);
        end
    endtask

    task automatic test_mismatch();
        clear_mem();
        rom[0] = 12'h0A5; rom[1] = 12'h5FF; rom[2] = 12'h012;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A4);
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd0 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL mismatch_fetch: rom_addr=%0h dac_we=%0b, want 0/0", rom_addr, dac_we);
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd1 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL mismatch_wait: rom_addr=%0h dac_we=%0b, want 1/0", rom_addr, dac_we);
        end
        send_main(9'h0A5);
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b1 || dac_data !== 9'h1FF) begin
            nerr++;
            $display("FAIL mismatch_retry: dac_we=%0b dac_data=%0h, want 1/1ff", dac_we, dac_data);
        end
    endtask

    task automatic test_delay();
        clear_mem();
        rom[0] = 12'h0A5; rom[1] = 12'h802; rom[2] = 12'h012;
        dtab[1] = 32'd3;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A5);
        @(negedge clk);
        nvec++;
        if (delay_idx !== 8'd1 || rom_addr !== 8'd2) begin
            nerr++;
            $display("FAIL delay_prep: delay_idx=%0h rom_addr=%0h, want 1/2", delay_idx, rom_addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (rom_addr !== 8'd2 || delay_idx !== 8'd0 || dac_we !== 1'b0) begin
                nerr++;
                $display("FAIL delay_hold[%0d]: rom_addr=%0h delay_idx=%0h dac_we=%0b, want 2/0/0",
                         i, rom_addr, delay_idx, dac_we);
            end
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd3) begin
            nerr++;
            $display("FAIL delay_done: rom_addr=%0h, want 3", rom_addr);
        end
    endtask

    task automatic test_parcel_two();
        clear_mem();
        rom[0] = 12'h0A5; rom[1] = 12'h5FF; rom[2] = 12'h012; rom[3] = 12'h5AA;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A5);
        repeat (2) @(negedge clk);
        send_main(9'h013);
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd2) begin
            nerr++;
            $display("FAIL parcel2_restart: rom_addr=%0h, want 2", rom_addr);
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd3) begin
            nerr++;
            $display("FAIL parcel2_wait: rom_addr=%0h, want 3", rom_addr);
        end
        send_main(9'h012);
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b1 || dac_data !== 9'h1AA) begin
            nerr++;
            $display("FAIL parcel2_dac: dac_we=%0b dac_data=%0h, want 1/1aa", dac_we, dac_data);
        end
    endtask

    task automatic test_priv_select();
        clear_mem();
        rom[0] = 12'h2A5; rom[1] = 12'h5AA;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A5);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (dac_we !== 1'b0 || rom_addr !== 8'd1) begin
                nerr++;
                $display("FAIL priv_ignore_main[%0d]: dac_we=%0b rom_addr=%0h, want 0/1",
                         i, dac_we, rom_addr);
            end
            @(negedge clk);
        end
        i2c_priv   = 9'h0A5;
        priv_ready = 1'b1;
        @(negedge clk);
        priv_ready = 1'b0;
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b1 || dac_data !== 9'h1AA) begin
            nerr++;
            $display("FAIL priv_advance: dac_we=%0b dac_data=%0h, want 1/1aa", dac_we, dac_data);
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        rom[0] = 12'h0A5; rom[1] = 12'h411; rom[2] = 12'h412; rom[3] = 12'h413;
        do_reset();
        repeat (2) @(negedge clk);
        send_main(9'h0A5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (dac_we !== 1'b1 || dac_data !== 9'(9'h011 + i)) begin
                nerr++;
                $display("FAIL b2b_dac[%0d]: dac_we=%0b dac_data=%0h, want 1/%0h",
                         i, dac_we, dac_data, 9'h011 + i);
            end
        end
        @(negedge clk);
        nvec++;
        if (dac_we !== 1'b0 || rom_addr !== 8'd5) begin
            nerr++;
            $display("FAIL b2b_end: dac_we=%0b rom_addr=%0h, want 0/5", dac_we, rom_addr);
        end
    endtask

    // Random parcels over the whole ROM; the interpreter walks words, not states.
    task automatic test_random();
        logic [7:0]  a, ps, nxt;
        logic [11:0] w;
        logic [8:0]  word;
        logic        prev_act, good;
        int          gi, k;

        gi = 0;
        while (gi < 256) begin
            for (int m = 0; m < 1 + int'($urandom % 2) && gi < 256; m++) begin
                rom[gi] = {2'b00, 1'($urandom), 9'($urandom)};
                gi++;
            end
            for (int m = 0; m < 1 + int'($urandom % 3) && gi < 256; m++) begin
                if ($urandom % 3 == 2) rom[gi] = {1'b1, 2'($urandom), 9'($urandom)};
                else rom[gi] = {2'b01, 1'($urandom), 9'($urandom)};
                gi++;
            end
        end
        for (int i = 0; i < 256; i++) dtab[i] = $urandom % 6;

        do_reset();
        nvec++;
        if (rom_addr !== 8'd0 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL rnd_init: rom_addr=%0h dac_we=%0b, want 0/0", rom_addr, dac_we);
        end
        @(negedge clk);
        nvec++;
        if (rom_addr !== 8'd0 || dac_we !== 1'b0) begin
            nerr++;
            $display("FAIL rnd_fetch: rom_addr=%0h dac_we=%0b, want 0/0", rom_addr, dac_we);
        end
        @(negedge clk);

        a = 8'd0; ps = 8'd0; prev_act = 1'b0;
        for (int step = 0; step < 600; step++) begin
            w   = rom[a];
            nxt = a + 8'd1;
            if (w[11]) begin
                nvec++;
                if (rom_addr !== nxt || delay_idx !== w[8:1] || dac_we !== 1'b0) begin
                    nerr++;
                    $display("FAIL rnd_prep@%0h: rom_addr=%0h delay_idx=%0h dac_we=%0b, want %0h/%0h/0",
                             a, rom_addr, delay_idx, dac_we, nxt, w[8:1]);
                end
                @(negedge clk);
                for (int j = 0; j < int'(dtab[w[8:1]]) + 2; j++) begin
                    nvec++;
                    if (rom_addr !== nxt || delay_idx !== 8'd0 || dac_we !== 1'b0) begin
                        nerr++;
                        $display("FAIL rnd_delay@%0h: rom_addr=%0h delay_idx=%0h dac_we=%0b, want %0h/0/0",
                                 a, rom_addr, delay_idx, dac_we, nxt);
                    end
                    @(negedge clk);
                end
                a = nxt; prev_act = 1'b1;
            end else if (w[10]) begin
                nvec++;
                if (rom_addr !== nxt || dac_we !== 1'b1 || dac_data !== w[8:0]) begin
                    nerr++;
                    $display("FAIL rnd_dac@%0h: rom_addr=%0h dac_we=%0b dac_data=%0h, want %0h/1/%0h",
                             a, rom_addr, dac_we, dac_data, nxt, w[8:0]);
                end
                @(negedge clk);
                a = nxt; prev_act = 1'b1;
            end else begin
                if (prev_act) ps = a;
                prev_act = 1'b0;
                k    = $urandom % 3;
                good = ($urandom % 4) != 0;
                word = good ? w[8:0] : (w[8:0] ^ (9'd1 << ($urandom % 9)));
                for (int j = 0; j <= k + 1; j++) begin
                    // j<k: idle, j==k: ready pulse, j==k+1: check cycle with word held.
                    if (w[9]) begin
                        priv_ready = (j == k); i2c_priv = word;
                        main_ready = 1'($urandom); i2c_main = 9'($urandom);
                    end else begin
                        main_ready = (j == k); i2c_main = word;
                        priv_ready = 1'($urandom); i2c_priv = 9'($urandom);
                    end
                    nvec++;
                    if (rom_addr !== nxt || dac_we !== 1'b0 || delay_idx !== 8'd0) begin
                        nerr++;
                        $display("FAIL rnd_match@%0h: rom_addr=%0h dac_we=%0b delay_idx=%0h, want %0h/0/0",
                                 a, rom_addr, dac_we, delay_idx, nxt);
                    end
                    @(negedge clk);
                end
                main_ready = 1'b0;
                priv_ready = 1'b0;
                if (good) begin
                    a = nxt;
                end else begin
                    nvec++;
                    if (rom_addr !== ps || dac_we !== 1'b0) begin
                        nerr++;
                        $display("FAIL rnd_restart@%0h: rom_addr=%0h dac_we=%0b, want %0h/0",
                                 a, rom_addr, dac_we, ps);
                    end
                    @(negedge clk);
                    a = ps;
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        main_ready = 1'b0;
        priv_ready = 1'b0;
        i2c_main   = 9'd0;
        i2c_priv   = 9'd0;
        test_reset();
        test_match_dac();
        test_mismatch();
        test_delay();
        test_parcel_two();
        test_priv_select();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
